// File: rtl/spi_channel_router.sv
// Routes SPI {addr,data} to per-channel FIFOs; round-robin arbitration upstream.
// Optional registered send_parity under `define SPI_CHANNEL_ROUTER_PARITY_EN.
module spi_channel_router #(
   parameter int  NUM_CHANNELS = 4,
   parameter int  DATA_BITS    = 8,
   parameter int  FIFO_DEPTH   = 2,
   localparam int ADDR_BITS    =
      (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ADDR_BITS+DATA_BITS-1:0]    recv_msg,
   input  logic                              recv_val,
   output logic                              recv_rdy,
   output logic [ADDR_BITS+DATA_BITS-1:0]    send_msg,
   output logic                              send_val,
   input  logic                              send_rdy,
   output logic [NUM_CHANNELS*DATA_BITS-1:0] chan_send_msg,
   output logic [NUM_CHANNELS-1:0]           chan_send_val,
   input  logic [NUM_CHANNELS-1:0]           chan_send_rdy,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0] chan_recv_msg,
   input  logic [NUM_CHANNELS-1:0]           chan_recv_val,
   output logic [NUM_CHANNELS-1:0]           chan_recv_rdy,
   output logic                              err_bad_addr,
   output logic                              send_parity
);

   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam int MSG_BITS = ADDR_BITS + DATA_BITS;

   logic [ADDR_BITS-1:0]    recv_addr;
   logic [DATA_BITS-1:0]    recv_data;
   logic                    recv_addr_ok;
   logic                    recv_fire;
   logic                    sel_full;
   logic [NUM_CHANNELS-1:0] fifo_full;
   logic [NUM_CHANNELS-1:0] enq;
   logic [NUM_CHANNELS-1:0] deq;

   assign {recv_addr, recv_data} = recv_msg;
   assign recv_addr_ok =
      {1'b0, recv_addr} < (ADDR_BITS+1)'(NUM_CHANNELS);

   always_comb begin
      sel_full = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (recv_addr == ADDR_BITS'(i)) sel_full = fifo_full[i];
      end
      recv_rdy = !reset && (!recv_addr_ok || !sel_full);
   end

   assign recv_fire = recv_val && recv_rdy;

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
      logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
      logic [PTR_BITS-1:0]  wr_ptr;
      logic [PTR_BITS-1:0]  rd_ptr;
      logic [PTR_BITS:0]    count;

      assign fifo_full[g] = count == (PTR_BITS+1)'(FIFO_DEPTH);
      assign enq[g] = recv_fire && (recv_addr == ADDR_BITS'(g));
      assign deq[g] = chan_send_val[g] && chan_send_rdy[g];
      assign chan_send_val[g] = !reset && (count != '0);
      assign chan_send_msg[g*DATA_BITS +: DATA_BITS] = mem[rd_ptr];

      always_ff @(posedge clk) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (enq[g]) wr_ptr <= wr_ptr + 1'b1;
            if (deq[g]) rd_ptr <= rd_ptr + 1'b1;
            if (enq[g] && !deq[g]) count <= count + 1'b1;
            else if (!enq[g] && deq[g]) count <= count - 1'b1;
         end
      end

      // Payload storage needs no reset; count gates visibility.
      always_ff @(posedge clk) begin
         if (enq[g]) mem[wr_ptr] <= recv_data;
      end
   end

   logic [ADDR_BITS-1:0] rr_ptr;
   logic [ADDR_BITS-1:0] rr_next;
   logic [ADDR_BITS-1:0] gnt_idx;
   logic                 gnt_any;
   logic                 gnt_fire;
   logic [DATA_BITS-1:0] gnt_data;
   logic                 out_val;
   logic [MSG_BITS-1:0]  out_msg;
   logic                 load_ok;
   logic                 send_fire;
   logic                 err_q;

   always_comb begin
      logic [ADDR_BITS:0] idx;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         idx = {1'b0, rr_ptr} + (ADDR_BITS+1)'(k);
         if (idx >= (ADDR_BITS+1)'(NUM_CHANNELS))
            idx = idx - (ADDR_BITS+1)'(NUM_CHANNELS);
         if (!gnt_any && chan_recv_val[idx[ADDR_BITS-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = idx[ADDR_BITS-1:0];
         end
      end
   end

   assign send_fire = send_val && send_rdy;
   assign load_ok   = !reset && (!out_val || send_fire);
   assign gnt_fire  = load_ok && gnt_any;
   assign gnt_data  = chan_recv_msg[gnt_idx*DATA_BITS +: DATA_BITS];
   assign rr_next   = (gnt_idx == ADDR_BITS'(NUM_CHANNELS-1)) ?
                      '0 : gnt_idx + 1'b1;

   assign chan_recv_rdy =
      gnt_fire ? (NUM_CHANNELS'(1) << gnt_idx) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_val <= 1'b0;
         out_msg <= '0;
         rr_ptr  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (gnt_fire) begin
            out_val <= 1'b1;
            out_msg <= {gnt_idx, gnt_data};
            rr_ptr  <= rr_next;
         end else if (send_fire) begin
            out_val <= 1'b0;
         end
         if (recv_fire && !recv_addr_ok) err_q <= 1'b1;
      end
   end

   assign send_val     = out_val && !reset;
   assign send_msg     = out_msg;
   assign err_bad_addr = err_q && !reset;

`ifdef SPI_CHANNEL_ROUTER_PARITY_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (reset) par_q <= 1'b0;
      else if (gnt_fire) par_q <= ^{gnt_idx, gnt_data};
   end

   assign send_parity = par_q && !reset;
`else
   assign send_parity = 1'b0;
`endif

endmodule

// File: tb/tb_spi_channel_router.sv
// Directed bench for spi_channel_router: 4-channel main DUT plus a
// 3-channel instance for the out-of-range address case.
module tb_spi_channel_router;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [9:0]  recv_msg = '0;
   logic        recv_val = 1'b0;
   logic        recv_rdy;
   logic [9:0]  send_msg;
   logic        send_val;
   logic        send_rdy = 1'b0;
   logic [31:0] chan_send_msg;
   logic [3:0]  chan_send_val;
   logic [3:0]  chan_send_rdy = '0;
   logic [31:0] chan_recv_msg = '0;
   logic [3:0]  chan_recv_val = '0;
   logic [3:0]  chan_recv_rdy;
   logic        err_bad_addr;
   logic        send_parity;

   logic [9:0]  r2_msg = '0;
   logic        r2_val = 1'b0;
   logic        r2_rdy;
   logic [9:0]  s2_msg;
   logic        s2_val;
   logic [23:0] c2_smsg;
   logic [2:0]  c2_sval;
   logic [2:0]  c2_rrdy;
   logic        err2;
   logic        par2;

   spi_channel_router #(
      .NUM_CHANNELS(4), .DATA_BITS(8), .FIFO_DEPTH(2)
   ) dut (
      .clk(clk), .reset(reset),
      .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
      .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
      .chan_send_msg(chan_send_msg), .chan_send_val(chan_send_val),
      .chan_send_rdy(chan_send_rdy),
      .chan_recv_msg(chan_recv_msg), .chan_recv_val(chan_recv_val),
      .chan_recv_rdy(chan_recv_rdy),
      .err_bad_addr(err_bad_addr), .send_parity(send_parity)
   );

   spi_channel_router #(
      .NUM_CHANNELS(3), .DATA_BITS(8), .FIFO_DEPTH(2)
   ) dut3 (
      .clk(clk), .reset(reset),
      .recv_msg(r2_msg), .recv_val(r2_val), .recv_rdy(r2_rdy),
      .send_msg(s2_msg), .send_val(s2_val), .send_rdy(1'b0),
      .chan_send_msg(c2_smsg), .chan_send_val(c2_sval),
      .chan_send_rdy(3'b000),
      .chan_recv_msg(24'h0), .chan_recv_val(3'b000),
      .chan_recv_rdy(c2_rrdy),
      .err_bad_addr(err2), .send_parity(par2)
   );

`ifdef SPI_CHANNEL_ROUTER_PARITY_EN
   localparam logic PAR_ON = 1'b1;
`else
   localparam logic PAR_ON = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rv;
      logic [1:0] addr;
      logic [7:0] data;
      logic [3:0] csr;
      logic       e_rrdy;
      logic [3:0] e_csv;
      logic       hchk;
      logic [1:0] hch;
      logic [7:0] e_head;
   } vec_t;

   vec_t tbl [12];
   logic [9:0] pm;
   int c;

   initial begin
      tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
      tbl[1]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
      tbl[2]  = '{1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
      tbl[3]  = '{1'b1, 2'd1, 8'h22, 4'b0000, 1'b1, 4'b0110, 1'b1, 2'd1, 8'h11};
      tbl[4]  = '{1'b1, 2'd1, 8'h33, 4'b0000, 1'b0, 4'b0110, 1'b1, 2'd1, 8'h11};
      tbl[5]  = '{1'b1, 2'd1, 8'h33, 4'b0010, 1'b0, 4'b0110, 1'b1, 2'd1, 8'h11};
      tbl[6]  = '{1'b1, 2'd1, 8'h33, 4'b0000, 1'b1, 4'b0110, 1'b1, 2'd1, 8'h22};
      tbl[7]  = '{1'b0, 2'd0, 8'h00, 4'b0110, 1'b1, 4'b0110, 1'b1, 2'd1, 8'h22};
      tbl[8]  = '{1'b1, 2'd1, 8'h44, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h33};
      tbl[9]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h44};
      tbl[10] = '{1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h44};
      tbl[11] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};

      // Reset values, sampled while reset is still high
      tick();
      tick();
      chk("rst recv_rdy", recv_rdy, 0);
      chk("rst send_val", send_val, 0);
      chk("rst chan_send_val", chan_send_val, 0);
      chk("rst chan_recv_rdy", chan_recv_rdy, 0);
      chk("rst err", err_bad_addr, 0);
      chk("rst parity", send_parity, 0);
      reset = 1'b0;
      #1;
      chk("post-rst recv_rdy", recv_rdy, 1);
      chk("post-rst err3", err2, 0);

      // Out-of-range address on the 3-channel instance
      r2_val = 1'b1;
      r2_msg = {2'd3, 8'h00};
      #1;
      chk("bad addr recv_rdy", r2_rdy, 1);
      tick();
      r2_val = 1'b0;
      #1;
      chk("bad addr err set", err2, 1);
      chk("bad addr no fifo", c2_sval, 0);

      // Downstream FIFO vectors
      for (int i = 0; i < 12; i++) begin
         recv_val      = tbl[i].rv;
         recv_msg      = {tbl[i].addr, tbl[i].data};
         chan_send_rdy = tbl[i].csr;
         #1;
         chk($sformatf("row%0d recv_rdy", i), recv_rdy, tbl[i].e_rrdy);
         chk($sformatf("row%0d chan_send_val", i), chan_send_val,
             tbl[i].e_csv);
         if (tbl[i].hchk)
            chk($sformatf("row%0d head", i),
                chan_send_msg[tbl[i].hch*8 +: 8], tbl[i].e_head);
         tick();
      end
      recv_val      = 1'b0;
      chan_send_rdy = '0;
      #1;
      chk("bad addr err held", err2, 1);

      // Round-robin with all channels requesting
      chan_recv_msg = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      chan_recv_val = 4'b1111;
      send_rdy      = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr%0d chan_recv_rdy", k), chan_recv_rdy,
             32'(4'b0001 << (k % 4)));
         chk($sformatf("rr%0d send_val", k), send_val, (k > 0) ? 1 : 0);
         if (k > 0) begin
            c = (k - 1) % 4;
            chk($sformatf("rr%0d send_msg", k), send_msg,
                {c[1:0], 8'hC0 + 8'(c)});
         end
         tick();
      end
      chan_recv_val = '0;
      tick();
      chk("rr drain", send_val, 0);

      // Back-pressure hold of {1,3C}
      chan_recv_msg = {8'hC3, 8'hC2, 8'h3C, 8'hC0};
      chan_recv_val = 4'b0010;
      send_rdy      = 1'b0;
      #1;
      chk("hold grant", chan_recv_rdy, 4'b0010);
      tick();
      pm = 10'h13C;
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("hold%0d send_val", j), send_val, 1);
         chk($sformatf("hold%0d send_msg", j), send_msg, 10'h13C);
         chk($sformatf("hold%0d chan_recv_rdy", j), chan_recv_rdy, 0);
         chk($sformatf("hold%0d parity", j), send_parity, PAR_ON & (^pm));
         tick();
      end
      send_rdy = 1'b1;
      #1;
      chk("hold release grant", chan_recv_rdy, 4'b0010);
      chan_recv_val = '0;
      tick();
      chk("hold drained", send_val, 0);

      // Occupy channels 0 and 3, load output, then reset mid-operation
      recv_val = 1'b1;
      recv_msg = {2'd0, 8'h5A};
      tick();
      recv_msg = {2'd3, 8'h7E};
      tick();
      recv_val      = 1'b0;
      send_rdy      = 1'b0;
      chan_recv_val = 4'b0100;
      #1;
      chk("pre-rst grant", chan_recv_rdy, 4'b0100);
      tick();
      chan_recv_val = '0;
      #1;
      chk("pre-rst occupancy", chan_send_val, 4'b1001);
      chk("pre-rst send_val", send_val, 1);
      reset         = 1'b1;
      recv_val      = 1'b1;
      recv_msg      = {2'd0, 8'h99};
      chan_recv_val = 4'b1111;
      send_rdy      = 1'b1;
      #1;
      chk("mid-rst recv_rdy", recv_rdy, 0);
      chk("mid-rst chan_send_val", chan_send_val, 0);
      chk("mid-rst send_val", send_val, 0);
      chk("mid-rst chan_recv_rdy", chan_recv_rdy, 0);
      chk("mid-rst err3", err2, 0);
      tick();
      reset    = 1'b0;
      recv_val = 1'b0;
      send_rdy = 1'b0;
      #1;
      chk("after-rst chan_send_val", chan_send_val, 0);
      chk("after-rst send_val", send_val, 0);
      chk("after-rst rr start", chan_recv_rdy, 4'b0001);
      chk("after-rst err3", err2, 0);
      tick();
      chan_recv_val = '0;
      #1;
      chk("after-rst send_msg", send_msg, {2'd0, 8'hC0});
      chk("after-rst send_val1", send_val, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_channel_router.md
SPI_CHANNEL_ROUTER -- requirements
Module: spi_channel_router

Interface
REQ-001 SHALL provide parameter NUM_CHANNELS, default 4, number of routed channels (2..16).
REQ-002 SHALL provide parameter DATA_BITS, default 8, payload width per channel.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 2, entries per channel FIFO (power of two, >=2).
REQ-004 SHALL provide localparam ADDR_BITS, equal to max(1, clog2(NUM_CHANNELS)), the channel-index width.
REQ-005 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL provide port recv_msg, input, ADDR_BITS+DATA_BITS, {addr, data} from the SPI minion adapter.
REQ-008 SHALL provide ports recv_val (input, 1) and recv_rdy (output, 1), the handshake for recv_msg.
REQ-009 SHALL provide port send_msg, output, ADDR_BITS+DATA_BITS, {source channel, data} to the SPI minion adapter.
REQ-010 SHALL provide ports send_val (output, 1) and send_rdy (input, 1), the handshake for send_msg.
REQ-011 SHALL provide port chan_send_msg, output, NUM_CHANNELS*DATA_BITS, per-channel FIFO head; channel i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-012 SHALL provide ports chan_send_val (output, NUM_CHANNELS) and chan_send_rdy (input, NUM_CHANNELS), per-channel handshake.
REQ-013 SHALL provide port chan_recv_msg, input, NUM_CHANNELS*DATA_BITS, per-channel upstream data, packed as chan_send_msg.
REQ-014 SHALL provide ports chan_recv_val (input, NUM_CHANNELS) and chan_recv_rdy (output, NUM_CHANNELS), per-channel handshake.
REQ-015 SHALL provide ports err_bad_addr (output, 1), sticky bad-address flag, and send_parity (output, 1), parity of send_msg.

Function
REQ-016 SHALL transfer on any interface only in a cycle where val and rdy are both high.
REQ-017 SHALL hold recv_rdy high when addr >= NUM_CHANNELS, or when the FIFO of channel addr is not full; recv_rdy is combinational on recv_msg.
REQ-018 SHALL enqueue data into the FIFO of channel addr on a recv transfer; enqueued data appears on chan_send_msg/chan_send_val no earlier than the next cycle (no bypass).
REQ-019 SHALL, when full, hold recv_rdy low for that channel even if a dequeue occurs in the same cycle (no pass-through).
REQ-020 SHALL support simultaneous enqueue and dequeue on a non-full, non-empty FIFO with occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL accept and discard a recv transfer with addr >= NUM_CHANNELS, and set err_bad_addr the next cycle; err_bad_addr clears only on reset.
REQ-022 SHALL use a one-entry upstream output register that is loadable when empty, or when send_val && send_rdy in the same cycle.
REQ-023 SHALL, when the output register is loadable, grant exactly one requesting channel by round-robin, raising chan_recv_rdy only for the granted channel; all chan_recv_rdy are low otherwise.
REQ-024 SHALL start round-robin priority at channel 0 and, after a grant to channel i, give highest priority to (i+1) mod NUM_CHANNELS; priority is unchanged with no grant.
REQ-025 SHALL present {i, data} on send_msg with send_val high the cycle after the grant, and hold it stable until send_rdy.
REQ-026 SHALL operate the downstream and upstream paths independently and concurrently.

Reset
REQ-027 SHALL, with reset high at a clock edge, empty all FIFOs and the output register, clear the round-robin priority to 0, and clear err_bad_addr.
REQ-028 SHALL drive send_val=0, chan_send_val=0, chan_recv_rdy=0, err_bad_addr=0 and send_parity=0 during reset; recv_rdy SHALL be 0 during reset.
REQ-029 SHALL discard in-flight data on reset asserted mid-operation, with no transfer completing in that cycle.

Configuration
REQ-030 SHALL, with macro SPI_CHANNEL_ROUTER_PARITY_EN defined, register send_parity = XOR reduction of send_msg, loaded with the output register.
REQ-031 SHALL, without SPI_CHANNEL_ROUTER_PARITY_EN, tie send_parity to 0 and instantiate no parity logic; all other behaviour is identical.

Verification (NUM_CHANNELS=4, DATA_BITS=8, FIFO_DEPTH=2)
REQ-032 SHALL cover: recv {2,8'hA5} -> chan_send_val=4'b0100 and chan_send_msg[23:16]=A5 the next cycle, with other channels idle.
REQ-033 SHALL cover: three recvs to channel 1 with chan_send_rdy=0 -> first two accepted, recv_rdy=0 on the third; one dequeue -> third accepted one cycle later.
REQ-034 SHALL cover: all chan_recv_val=4'b1111 with send_rdy=1 -> send_msg channel order 0,1,2,3,0, one per cycle.
REQ-035 SHALL cover: recv {3,8'h00} with NUM_CHANNELS=3 -> transfer accepted, no FIFO change, err_bad_addr=1 held until reset.
REQ-036 SHALL cover: send_rdy=0 with send_msg={1,8'h3C} held -> chan_recv_rdy=0, msg stable; with the macro defined, send_parity=1 (XOR of 10'b01_0011_1100).
REQ-037 SHALL cover: reset pulsed with two channel FIFOs occupied -> all val outputs 0 the next cycle, and the next arbitration starts at channel 0.
